// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and widths for the data-memory port arbiter.
// Optional stall counters are built only when DMEM_ARB_PERF_EN is defined.
package dmem_port_arbiter_pkg;

   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_PD_W   = 7;
   localparam int DMEM_ROB_W  = 5;
   localparam int DMEM_PERF_W = 32;

   typedef enum logic {
      IDLE    = 1'b0,
      LD_WAIT = 1'b1
   } dmem_arb_state_t;

   typedef struct packed {
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_PD_W-1:0]   pd;
      logic [DMEM_ROB_W-1:0]  rob;
   } dmem_ld_req_t;

   typedef struct packed {
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] data;
   } dmem_st_req_t;

   // Bits needed to hold a countdown from n-1 to 0 (never narrower than one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of load/store request, memory bus, load response and perf signals.
// slave = the arbiter, master = requesters plus memory.
interface dmem_port_arbiter_if;
   import dmem_port_arbiter_pkg::*;

   logic                   ld_req_valid;
   logic                   ld_req_ready;
   logic [DMEM_ADDR_W-1:0] ld_req_addr;
   logic [DMEM_PD_W-1:0]   ld_req_pd;
   logic [DMEM_ROB_W-1:0]  ld_req_rob;

   logic                   st_req_valid;
   logic                   st_req_ready;
   logic [DMEM_ADDR_W-1:0] st_req_addr;
   logic [DMEM_DATA_W-1:0] st_req_data;
   logic                   st_urgent;

   logic                   flush;

   logic                   mem_en;
   logic                   mem_we;
   logic [DMEM_ADDR_W-1:0] mem_addr;
   logic [DMEM_DATA_W-1:0] mem_wdata;
   logic [DMEM_DATA_W-1:0] mem_rdata;

   logic                   ld_resp_valid;
   logic [DMEM_DATA_W-1:0] ld_resp_data;
   logic [DMEM_PD_W-1:0]   ld_resp_pd;
   logic [DMEM_ROB_W-1:0]  ld_resp_rob;

   logic [DMEM_PERF_W-1:0] perf_ld_stall;
   logic [DMEM_PERF_W-1:0] perf_st_stall;

   modport slave (
      input  ld_req_valid, ld_req_addr, ld_req_pd, ld_req_rob,
      input  st_req_valid, st_req_addr, st_req_data, st_urgent,
      input  flush, mem_rdata,
      output ld_req_ready, st_req_ready,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output ld_resp_valid, ld_resp_data, ld_resp_pd, ld_resp_rob,
      output perf_ld_stall, perf_st_stall
   );

   modport master (
      output ld_req_valid, ld_req_addr, ld_req_pd, ld_req_rob,
      output st_req_valid, st_req_addr, st_req_data, st_urgent,
      output flush, mem_rdata,
      input  ld_req_ready, st_req_ready,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  ld_resp_valid, ld_resp_data, ld_resp_pd, ld_resp_rob,
      input  perf_ld_stall, perf_st_stall
   );

endinterface

// File: rtl/dmem_port_arbiter_perf_ctr.sv
// Free-running wrapping stall counters for the load and store request ports.
// Instantiated by dmem_port_arbiter only when DMEM_ARB_PERF_EN is defined.
module dmem_arb_perf_ctr
   import dmem_port_arbiter_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ld_stall_i,
   input  logic                   st_stall_i,
   output logic [DMEM_PERF_W-1:0] ld_stall_cnt_o,
   output logic [DMEM_PERF_W-1:0] st_stall_cnt_o
);

   logic [DMEM_PERF_W-1:0] ld_cnt_q, ld_cnt_d;
   logic [DMEM_PERF_W-1:0] st_cnt_q, st_cnt_d;

   assign ld_cnt_d = ld_stall_i ? ld_cnt_q + DMEM_PERF_W'(1) : ld_cnt_q;
   assign st_cnt_d = st_stall_i ? st_cnt_q + DMEM_PERF_W'(1) : st_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_cnt_q <= '0;
         st_cnt_q <= '0;
      end else begin
         ld_cnt_q <= ld_cnt_d;
         st_cnt_q <= st_cnt_d;
      end
   end

   assign ld_stall_cnt_o = ld_cnt_q;
   assign st_stall_cnt_o = st_cnt_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between issued loads and retired-store commits,
// tracks read latency and returns tagged load data. Stall counters under DMEM_ARB_PERF_EN.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int MEM_LAT       = 2,
   parameter int MAX_LD_STREAK = 4,
   parameter int STREAK_W      = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   dmem_port_arbiter_if.slave   bus
);

   localparam int LAT_W = cnt_width(MEM_LAT);
   localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(MEM_LAT - 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LD_STREAK);

   dmem_arb_state_t       state_q, state_d;
   logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
   logic [STREAK_W-1:0]   streak_q, streak_d;
   logic                  killed_q, killed_d;
   logic [DMEM_PD_W-1:0]  pd_q, pd_d;
   logic [DMEM_ROB_W-1:0] rob_q, rob_d;

   dmem_ld_req_t ld_req;
   dmem_st_req_t st_req;
   logic         port_live;
   logic         ld_eligible;
   logic         ld_grant;
   logic         st_grant;
   logic         resp_fire;

   assign ld_req = '{addr: bus.ld_req_addr, pd: bus.ld_req_pd, rob: bus.ld_req_rob};
   assign st_req = '{addr: bus.st_req_addr, data: bus.st_req_data};

   // Gating with reset keeps every output at 0 while reset is held, even mid-cycle.
   assign port_live   = (state_q == IDLE) && reset;
   assign ld_eligible = bus.ld_req_valid && !bus.flush;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      streak_d  = streak_q;
      killed_d  = killed_q;
      pd_d      = pd_q;
      rob_d     = rob_q;
      st_grant  = 1'b0;
      ld_grant  = 1'b0;
      resp_fire = 1'b0;

      case (state_q)
         IDLE: begin
            st_grant = port_live && bus.st_req_valid &&
                       (bus.st_urgent || !ld_eligible || (streak_q >= STREAK_MAX));
            ld_grant = port_live && ld_eligible && !st_grant;
            if (ld_grant) begin
               state_d   = LD_WAIT;
               lat_cnt_d = LAT_INIT;
               pd_d      = ld_req.pd;
               rob_d     = ld_req.rob;
            end
         end
         LD_WAIT: begin
            if (lat_cnt_q == '0) begin
               // The read always runs to completion; a flush only hides its response.
               resp_fire = reset && !killed_q && !bus.flush;
               state_d   = IDLE;
               killed_d  = 1'b0;
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
               if (bus.flush) killed_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (!bus.st_req_valid || st_grant) begin
         streak_d = '0;
      end else if (ld_grant && (streak_q < STREAK_MAX)) begin
         streak_d = streak_q + STREAK_W'(1);
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         lat_cnt_q <= '0;
         streak_q  <= '0;
         killed_q  <= 1'b0;
         pd_q      <= '0;
         rob_q     <= '0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         streak_q  <= streak_d;
         killed_q  <= killed_d;
         pd_q      <= pd_d;
         rob_q     <= rob_d;
      end
   end

   assign bus.ld_req_ready = ld_grant;
   assign bus.st_req_ready = st_grant;

   assign bus.mem_en    = ld_grant || st_grant;
   assign bus.mem_we    = st_grant;
   assign bus.mem_addr  = st_grant ? st_req.addr :
                          ld_grant ? ld_req.addr : '0;
   assign bus.mem_wdata = st_grant ? st_req.data : '0;

   assign bus.ld_resp_valid = resp_fire;
   assign bus.ld_resp_data  = resp_fire ? bus.mem_rdata : '0;
   assign bus.ld_resp_pd    = resp_fire ? pd_q : '0;
   assign bus.ld_resp_rob   = resp_fire ? rob_q : '0;

`ifdef DMEM_ARB_PERF_EN
   logic [DMEM_PERF_W-1:0] ld_stall_cnt;
   logic [DMEM_PERF_W-1:0] st_stall_cnt;

   dmem_arb_perf_ctr u_perf (
      .clk            (clk),
      .reset          (reset),
      .ld_stall_i     (bus.ld_req_valid && !ld_grant),
      .st_stall_i     (bus.st_req_valid && !st_grant),
      .ld_stall_cnt_o (ld_stall_cnt),
      .st_stall_cnt_o (st_stall_cnt)
   );

   assign bus.perf_ld_stall = ld_stall_cnt;
   assign bus.perf_st_stall = st_stall_cnt;
`else
   assign bus.perf_ld_stall = '0;
   assign bus.perf_st_stall = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter (MEM_LAT=2, MAX_LD_STREAK=4): inputs change on the
// falling edge, outputs are checked 1 ns later, well before the next rising edge.
module tb_dmem_port_arbiter;

   logic clk;
   logic reset;
   int   n_total;
   int   n_pass;
   int   n_writes;

   dmem_port_arbiter_if bus ();

   dmem_port_arbiter #(
      .MEM_LAT       (2),
      .MAX_LD_STREAK (4),
      .STREAK_W      (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic set_inputs(input logic ldv, input logic [31:0] ld_addr, input logic [6:0] pd,
                             input logic [4:0] rob, input logic stv, input logic [31:0] st_addr,
                             input logic [31:0] st_data, input logic urg, input logic fl,
                             input logic [31:0] rdata);
      bus.ld_req_valid = ldv;
      bus.ld_req_addr  = ld_addr;
      bus.ld_req_pd    = pd;
      bus.ld_req_rob   = rob;
      bus.st_req_valid = stv;
      bus.st_req_addr  = st_addr;
      bus.st_req_data  = st_data;
      bus.st_urgent    = urg;
      bus.flush        = fl;
      bus.mem_rdata    = rdata;
   endtask

   // One clock cycle: wait for the falling edge, apply inputs, let combinational outputs settle.
   task automatic drv(input logic ldv, input logic [31:0] ld_addr, input logic [6:0] pd,
                      input logic [4:0] rob, input logic stv, input logic [31:0] st_addr,
                      input logic [31:0] st_data, input logic urg, input logic fl,
                      input logic [31:0] rdata);
      @(negedge clk);
      set_inputs(ldv, ld_addr, pd, rob, stv, st_addr, st_data, urg, fl, rdata);
      #1;
   endtask

   initial begin
      n_total  = 0;
      n_pass   = 0;
      n_writes = 0;
      reset    = 1'b0;
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset held with both requests valid: nothing may leak out.
      drv(1, 32'h80, 7'd1, 5'd1, 1, 32'h90, 32'h5, 0, 0, 32'h0);
      check("rst_ld_ready", bus.ld_req_ready, 0);
      check("rst_st_ready", bus.st_req_ready, 0);
      check("rst_mem_en", bus.mem_en, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_resp_valid", bus.ld_resp_valid, 0);
      check("rst_perf_ld", bus.perf_ld_stall, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;

      // Basic load: grant at T, response at T+2, next grant at T+3.
      drv(1, 32'h40, 7'd12, 5'd3, 0, 0, 0, 0, 0, 0);
      check("ld1_ready", bus.ld_req_ready, 1);
      check("ld1_st_ready", bus.st_req_ready, 0);
      check("ld1_mem_en", bus.mem_en, 1);
      check("ld1_mem_we", bus.mem_we, 0);
      check("ld1_mem_addr", bus.mem_addr, 32'h40);
      drv(1, 32'h44, 7'd5, 5'd1, 0, 0, 0, 0, 0, 0);
      check("ld1_t1_ready", bus.ld_req_ready, 0);
      check("ld1_t1_mem_en", bus.mem_en, 0);
      check("ld1_t1_mem_addr", bus.mem_addr, 0);
      check("ld1_t1_resp", bus.ld_resp_valid, 0);
      drv(1, 32'h44, 7'd5, 5'd1, 0, 0, 0, 0, 0, 32'hDEADBEEF);
      check("ld1_resp_valid", bus.ld_resp_valid, 1);
      check("ld1_resp_data", bus.ld_resp_data, 32'hDEADBEEF);
      check("ld1_resp_pd", bus.ld_resp_pd, 12);
      check("ld1_resp_rob", bus.ld_resp_rob, 3);
      check("ld1_t2_ready", bus.ld_req_ready, 0);
      drv(1, 32'h44, 7'd5, 5'd1, 0, 0, 0, 0, 0, 32'h0);
      check("ld2_ready_t3", bus.ld_req_ready, 1);
      check("ld2_mem_addr", bus.mem_addr, 32'h44);
      check("ld2_t3_resp", bus.ld_resp_valid, 0);
      check("ld2_t3_resp_data", bus.ld_resp_data, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678);
      check("ld2_resp_valid", bus.ld_resp_valid, 1);
      check("ld2_resp_data", bus.ld_resp_data, 32'h12345678);
      check("ld2_resp_pd", bus.ld_resp_pd, 5);
      check("ld2_resp_rob", bus.ld_resp_rob, 1);

      // Load and store both valid, streak 0, not urgent: load first, store at T+3.
      drv(1, 32'h200, 7'd20, 5'd7, 1, 32'h300, 32'hCAFE0001, 0, 0, 0);
      check("mix_ld_ready", bus.ld_req_ready, 1);
      check("mix_st_ready", bus.st_req_ready, 0);
      check("mix_mem_we", bus.mem_we, 0);
      drv(0, 0, 0, 0, 1, 32'h300, 32'hCAFE0001, 0, 0, 0);
      check("mix_t1_st_ready", bus.st_req_ready, 0);
      check("mix_t1_mem_en", bus.mem_en, 0);
      drv(0, 0, 0, 0, 1, 32'h300, 32'hCAFE0001, 0, 0, 32'h0000A5A5);
      check("mix_resp_data", bus.ld_resp_data, 32'h0000A5A5);
      check("mix_resp_rob", bus.ld_resp_rob, 7);
      drv(0, 0, 0, 0, 1, 32'h300, 32'hCAFE0001, 0, 0, 0);
      check("mix_t3_st_ready", bus.st_req_ready, 1);
      check("mix_t3_mem_en", bus.mem_en, 1);
      check("mix_t3_mem_we", bus.mem_we, 1);
      check("mix_t3_mem_addr", bus.mem_addr, 32'h300);
      check("mix_t3_mem_wdata", bus.mem_wdata, 32'hCAFE0001);

      // Store waits through four back-to-back loads, then wins the fifth arbitration.
      for (int i = 0; i < 4; i++) begin
         drv(1, 32'h500 + 32'(4 * i), 7'(i), 5'(i), 1, 32'h400, 32'h77, 0, 0, 0);
         check($sformatf("streak_ld%0d_ready", i), bus.ld_req_ready, 1);
         drv(1, 32'h500, 7'd0, 5'd0, 1, 32'h400, 32'h77, 0, 0, 0);
         drv(1, 32'h500, 7'd0, 5'd0, 1, 32'h400, 32'h77, 0, 0, 32'h1000 + 32'(i));
         check($sformatf("streak_ld%0d_resp_rob", i), bus.ld_resp_rob, 32'(i));
      end
      drv(1, 32'h600, 7'd9, 5'd9, 1, 32'h400, 32'h77, 0, 0, 0);
      check("streak_st_ready", bus.st_req_ready, 1);
      check("streak_st_ld_ready", bus.ld_req_ready, 0);
      check("streak_st_mem_we", bus.mem_we, 1);
      check("streak_st_mem_addr", bus.mem_addr, 32'h400);
      drv(1, 32'h600, 7'd9, 5'd9, 1, 32'h400, 32'h77, 0, 0, 0);
      check("streak_reset_ld_ready", bus.ld_req_ready, 1);
      check("streak_reset_st_ready", bus.st_req_ready, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      check("streak_reset_resp_pd", bus.ld_resp_pd, 9);

      // Urgent store beats a valid load with streak 0.
      drv(1, 32'h610, 7'd2, 5'd2, 1, 32'h700, 32'h11, 1, 0, 0);
      check("urgent_st_ready", bus.st_req_ready, 1);
      check("urgent_ld_ready", bus.ld_req_ready, 0);
      check("urgent_mem_wdata", bus.mem_wdata, 32'h11);
`ifndef DMEM_ARB_PERF_EN
      check("perf_st_tied", bus.perf_st_stall, 0);
      check("perf_ld_tied", bus.perf_ld_stall, 0);
`endif

      // Flush while the read is outstanding suppresses its response.
      drv(1, 32'h800, 7'd30, 5'd10, 0, 0, 0, 0, 0, 0);
      check("flush_ld_ready", bus.ld_req_ready, 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("flush_t1_resp", bus.ld_resp_valid, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF0000);
      check("flush_t2_resp_valid", bus.ld_resp_valid, 0);
      check("flush_t2_resp_data", bus.ld_resp_data, 0);
      check("flush_t2_resp_pd", bus.ld_resp_pd, 0);
      drv(1, 32'h804, 7'd31, 5'd11, 0, 0, 0, 0, 0, 0);
      check("flush_t3_ld_ready", bus.ld_req_ready, 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1);
      check("flush_resp_cycle_valid", bus.ld_resp_valid, 0);
      drv(1, 32'h808, 7'd1, 5'd1, 0, 0, 0, 0, 1, 0);
      check("flush_blocks_ld_ready", bus.ld_req_ready, 0);
      check("flush_blocks_mem_en", bus.mem_en, 0);
      drv(1, 32'h808, 7'd1, 5'd1, 1, 32'h900, 32'h22, 1, 1, 0);
      check("flush_st_ready", bus.st_req_ready, 1);
      check("flush_st_mem_we", bus.mem_we, 1);

      // Eight consecutive stores, one per cycle.
      for (int i = 0; i < 8; i++) begin
         drv(0, 0, 0, 0, 1, 32'hA00 + 32'(4 * i), 32'(100 + i), 0, 0, 0);
         check($sformatf("st%0d_ready", i), bus.st_req_ready, 1);
         check($sformatf("st%0d_mem_addr", i), bus.mem_addr, 32'hA00 + 32'(4 * i));
         check($sformatf("st%0d_mem_wdata", i), bus.mem_wdata, 32'(100 + i));
         if (bus.mem_en && bus.mem_we) n_writes++;
      end
      check("st_burst_writes", 32'(n_writes), 8);

      // Reset asserted during the response cycle of an outstanding load.
      drv(1, 32'hB00, 7'd40, 5'd20, 0, 0, 0, 0, 0, 0);
      check("rst_ld_grant", bus.ld_req_ready, 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      bus.mem_rdata = 32'h00000BAD;
      #1;
      check("rst_wait_resp_valid", bus.ld_resp_valid, 0);
      check("rst_wait_resp_data", bus.ld_resp_data, 0);
      check("rst_wait_resp_rob", bus.ld_resp_rob, 0);
      @(negedge clk);
      reset = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000BAD);
      check("post_rst_resp_valid", bus.ld_resp_valid, 0);
      check("post_rst_perf_ld", bus.perf_ld_stall, 0);
      check("post_rst_perf_st", bus.perf_st_stall, 0);
      drv(1, 32'hC00, 7'd1, 5'd2, 0, 0, 0, 0, 0, 0);
      check("post_rst_ld_ready", bus.ld_req_ready, 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h55);
      check("post_rst_resp_valid2", bus.ld_resp_valid, 1);
      check("post_rst_resp_data", bus.ld_resp_data, 32'h55);
      check("post_rst_resp_rob", bus.ld_resp_rob, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
